mem_bus_sequencer: RTL and testbench

Sequences the CPU's single shared memory port between instruction fetch and data load/store in the 32-bit RISC core. Accepts level requests from the fetch controller and the execute stage, arbitrates round-robin on ties, and drives the MAR/MDR/IR/PC enables and the memory rd/wr strobes through a fixed multi-cycle access. Sits between the top-level controller and the memory/MAR/MDR datapath; owns the memory bus exclusively.

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/mem_wait_counter.sv | 32 +++
 rtl/mem_bus_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_bus_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the memory bus sequencer and its helpers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_WB      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_e;

  // Requester class remembered for round-robin tie breaking.
  typedef enum logic {
    GR_FETCH = 1'b0,
    GR_DATA  = 1'b1
  } grant_e;

  localparam logic MAR_SRC_PC   = 1'b0;
  localparam logic MAR_SRC_ADDR = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the rd/wr strobe window of one access.
module mem_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_sequencer.sv
// Owns the single memory port: arbitrates fetch vs data requests and walks
// each access through ADDR / ACCESS / CAPTURE (/ WB for loads).
module mem_bus_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fetchReq,
  input  logic ldReq,
  input  logic stReq,
  output logic marEn,
  output logic marSel,
  output logic mdrStEn,
  output logic mdrEn,
  output logic rd,
  output logic wr,
  output logic irEn,
  output logic pcEn,
  output logic wEn,
  output logic fetchDone,
  output logic dataDone,
  output logic busy
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  state_e state_q, state_d;
  kind_e  kind_q,  kind_d;
  grant_e last_q,  last_d;
  logic   cnt_load, cnt_dec, cnt_zero;
  logic   data_req;

  assign data_req = ldReq | stReq;

  mem_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CW'(MEM_WAIT - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State, kind and round-robin history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_FETCH;
      last_q  <= GR_DATA;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant in IDLE, then fixed walk through the access phases.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    last_d   = last_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetchReq && (!data_req || last_q == GR_DATA)) begin
          kind_d  = K_FETCH;
          last_d  = GR_FETCH;
          state_d = S_ADDR;
        end else if (data_req) begin
          // Load beats a simultaneous store; the store stays pending.
          kind_d  = ldReq ? K_LOAD : K_STORE;
          last_d  = GR_DATA;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_load = 1'b1;
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_zero) state_d = S_CAPTURE;
        else          cnt_dec = 1'b1;
      end
      S_CAPTURE: state_d = (kind_q == K_LOAD) ? S_WB : S_IDLE;
      S_WB:      state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and transaction kind only.
  always_comb begin
    marEn     = 1'b0;
    marSel    = MAR_SRC_PC;
    mdrStEn   = 1'b0;
    mdrEn     = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    irEn      = 1'b0;
    pcEn      = 1'b0;
    wEn       = 1'b0;
    fetchDone = 1'b0;
    dataDone  = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_ADDR: begin
        marEn   = 1'b1;
        marSel  = (kind_q == K_FETCH) ? MAR_SRC_PC : MAR_SRC_ADDR;
        mdrStEn = (kind_q == K_STORE);
      end
      S_ACCESS: begin
        rd = (kind_q != K_STORE);
        wr = (kind_q == K_STORE);
      end
      S_CAPTURE: begin
        case (kind_q)
          K_FETCH: begin
            irEn      = 1'b1;
            pcEn      = 1'b1;
            fetchDone = 1'b1;
          end
          K_LOAD:  mdrEn    = 1'b1;
          K_STORE: dataDone = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        wEn      = 1'b1;
        dataDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer with MEM_WAIT=2. Outputs are packed
// into one word {marEn,marSel,mdrStEn,mdrEn,rd,wr,irEn,pcEn,wEn,fetchDone,
// dataDone,busy} and compared cycle by cycle against hand-written vectors.
module tb_mem_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetchReq = 1'b0, ldReq = 1'b0, stReq = 1'b0;
  logic marEn, marSel, mdrStEn, mdrEn, rd, wr, irEn, pcEn, wEn;
  logic fetchDone, dataDone, busy;
  logic [11:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_sequencer #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset),
    .fetchReq(fetchReq), .ldReq(ldReq), .stReq(stReq),
    .marEn(marEn), .marSel(marSel), .mdrStEn(mdrStEn), .mdrEn(mdrEn),
    .rd(rd), .wr(wr), .irEn(irEn), .pcEn(pcEn), .wEn(wEn),
    .fetchDone(fetchDone), .dataDone(dataDone), .busy(busy)
  );

  assign outs = {marEn, marSel, mdrStEn, mdrEn, rd, wr, irEn, pcEn, wEn,
                 fetchDone, dataDone, busy};

  // Expected output words for each phase.
  localparam logic [11:0] O_IDLE = 12'h000;
  localparam logic [11:0] O_FADR = 12'h801; // marEn, marSel=PC
  localparam logic [11:0] O_RD   = 12'h081; // rd
  localparam logic [11:0] O_FCAP = 12'h035; // irEn, pcEn, fetchDone
  localparam logic [11:0] O_LADR = 12'hC01; // marEn, marSel=ADDR
  localparam logic [11:0] O_LCAP = 12'h101; // mdrEn
  localparam logic [11:0] O_LWB  = 12'h00B; // wEn, dataDone
  localparam logic [11:0] O_SADR = 12'hE01; // marEn, marSel=ADDR, mdrStEn
  localparam logic [11:0] O_WR   = 12'h041; // wr
  localparam logic [11:0] O_SCAP = 12'h003; // dataDone

  // Apply request vector {fetch,ld,st}, then wait to the next falling edge.
  task automatic step(input logic [2:0] req);
    {fetchReq, ldReq, stReq} = req;
    @(negedge clk);
  endtask

  task automatic test_reset();
    {fetchReq, ldReq, stReq} = 3'b111;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, outs, O_IDLE);
      end
    end
    reset = 1'b1;
    step(3'b111);
    checks++;
    if (outs !== O_FADR) begin
      errors++;
      $display("FAIL reset_first_grant: got %h want %h", outs, O_FADR);
    end
    // Requests dropped mid-transaction: the fetch still completes.
    begin
      logic [11:0] exp [4] = '{O_RD, O_RD, O_FCAP, O_IDLE};
      for (int i = 0; i < 4; i++) begin
        step(3'b000);
        checks++;
        if (outs !== exp[i]) begin
          errors++;
          $display("FAIL reset_drain cyc%0d: got %h want %h", i, outs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [2:0]  req [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
    logic [11:0] exp [6] = '{O_FADR, O_RD, O_RD, O_FCAP, O_IDLE, O_IDLE};
    for (int i = 0; i < 6; i++) begin
      step(req[i]);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL single_fetch cyc%0d: got %h want %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_load_store();
    logic [2:0]  req [12] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001,
                              3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    logic [11:0] exp [12] = '{O_LADR, O_RD, O_RD, O_LCAP, O_LWB, O_IDLE,
                              O_SADR, O_WR, O_WR, O_SCAP, O_IDLE, O_IDLE};
    for (int i = 0; i < 12; i++) begin
      step(req[i]);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL load_store cyc%0d: got %h want %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [11:0] exp [21] = '{O_FADR, O_RD, O_RD, O_FCAP, O_IDLE,
                              O_LADR, O_RD, O_RD, O_LCAP, O_LWB, O_IDLE,
                              O_FADR, O_RD, O_RD, O_FCAP, O_IDLE,
                              O_LADR, O_RD, O_RD, O_LCAP, O_LWB};
    int dones = 0;
    for (int i = 0; i < 21; i++) begin
      step(3'b110);
      dones += int'(fetchDone) + int'(dataDone);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL contention cyc%0d: got %h want %h", i, outs, exp[i]);
      end
    end
    checks++;
    if (dones !== 4) begin
      errors++;
      $display("FAIL contention_done_count: got %0d want 4", dones);
    end
    step(3'b000);
    step(3'b000);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL contention_idle: got %h want %h", outs, O_IDLE);
    end
  endtask

  task automatic test_ld_st_tie();
    logic [2:0]  req [12] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001,
                              3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    logic [11:0] exp [12] = '{O_LADR, O_RD, O_RD, O_LCAP, O_LWB, O_IDLE,
                              O_SADR, O_WR, O_WR, O_SCAP, O_IDLE, O_IDLE};
    for (int i = 0; i < 12; i++) begin
      step(req[i]);
      checks++;
      if (outs !== exp[i] || (rd && wr)) begin
        errors++;
        $display("FAIL ld_st_tie cyc%0d: got %h want %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    step(3'b010);
    step(3'b010);
    checks++;
    if (outs !== O_RD) begin
      errors++;
      $display("FAIL midrst_pre: got %h want %h", outs, O_RD);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL midrst_async_drop: got %h want %h", outs, O_IDLE);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL midrst_hold: got %h want %h", outs, O_IDLE);
    end
    reset = 1'b1;
    begin
      logic [2:0]  req [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                               3'b000, 3'b000};
      logic [11:0] exp [7] = '{O_LADR, O_RD, O_RD, O_LCAP, O_LWB,
                               O_IDLE, O_IDLE};
      for (int i = 0; i < 7; i++) begin
        step(req[i]);
        checks++;
        if (outs !== exp[i]) begin
          errors++;
          $display("FAIL midrst_restart cyc%0d: got %h want %h", i, outs, exp[i]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_load_store();
    test_contention();
    test_ld_st_tie();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
